add_pipe_nbit: RTL and testbench

//  Parametrised, pipelined N-bit adder/subtractor. Successor to the 4-bit combinational adder.

---
 rtl/add_pipe_nbit_pkg.sv | 17 +
 rtl/add_pipe_nbit_if.sv | 29 ++
 rtl/add_chunk.sv | 28 ++
 rtl/add_pipe_nbit.sv | 110 +++++++++++
 tb/tb_add_pipe_nbit.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/add_pipe_nbit_pkg.sv
// Shared types and defaults for the pipelined chunked adder/subtractor.
package add_pipe_nbit_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_CHUNK = 4;

    // Per-stage control carried alongside the data
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctrl_t;

    function automatic int unsigned num_stages(input int unsigned width, input int unsigned chunk);
        return (chunk == 0) ? 1 : width / chunk;
    endfunction

endpackage

// File: rtl/add_pipe_nbit_if.sv
// Operand/result stream bundle for add_pipe_nbit; master drives operands, slave is the adder.
interface add_pipe_nbit_if
    import add_pipe_nbit_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB for overflow.
module add_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    always_comb begin
        logic cy;
        cy       = ci;
        s        = '0;
        c_msb_in = 1'b0;
        for (int i = 0; i < int'(CHUNK); i++) begin
            if (i == int'(CHUNK) - 1) begin
                c_msb_in = cy;
            end
            s[i] = a[i] ^ b[i] ^ cy;
            cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        co = cy;
    end

endmodule

// File: rtl/add_pipe_nbit.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit ripple stage per register stage,
// whole pipe advances together under a single valid/ready enable.
module add_pipe_nbit
    import add_pipe_nbit_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic           clk,
    input  logic           rst,
    add_pipe_nbit_if.slave bus
);

    localparam int unsigned STAGES = num_stages(WIDTH, CHUNK);

    if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("add_pipe_nbit: WIDTH (%0d) must be a non-zero multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    // Stage boundaries: index k is the input of stage k, index k+1 its registered output
    logic [WIDTH-1:0] a_bnd    [STAGES];
    logic [WIDTH-1:0] b_bnd    [STAGES];
    logic [WIDTH-1:0] s_bnd    [STAGES+1];
    stage_ctrl_t      ctrl_bnd [STAGES+1];
    logic             co_c     [STAGES];
    logic             cmsb_c   [STAGES];
    logic             adv_c;
    logic             ovf_q;

    assign adv_c        = ~ctrl_bnd[STAGES].valid | bus.out_ready;
    assign bus.in_ready = adv_c;

    // Subtract as a + ~b + 1; a borrow-in simply cancels that +1
    assign a_bnd[0]    = bus.a;
    assign b_bnd[0]    = bus.sub ? ~bus.b : bus.b;
    assign s_bnd[0]    = '0;
    assign ctrl_bnd[0] = '{valid: bus.in_valid, carry: bus.cin ^ bus.sub};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] s_c;
        logic [WIDTH-1:0] s_d;
        logic [WIDTH-1:0] s_q;
        stage_ctrl_t      ctrl_d;
        stage_ctrl_t      ctrl_q;

        add_chunk #(
            .CHUNK(CHUNK)
        ) u_chunk (
            .a       (a_bnd[k][k*CHUNK +: CHUNK]),
            .b       (b_bnd[k][k*CHUNK +: CHUNK]),
            .ci      (ctrl_bnd[k].carry),
            .s       (s_c),
            .co      (co_c[k]),
            .c_msb_in(cmsb_c[k])
        );

        always_comb begin
            s_d                   = s_bnd[k];
            s_d[k*CHUNK +: CHUNK] = s_c;
            ctrl_d                = '{valid: ctrl_bnd[k].valid, carry: co_c[k]};
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                ctrl_q <= '0;
                s_q    <= '0;
            end else if (adv_c) begin
                ctrl_q <= ctrl_d;
                s_q    <= s_d;
            end
        end

        assign s_bnd[k+1]    = s_q;
        assign ctrl_bnd[k+1] = ctrl_q;

        // Operands are only forwarded while there are chunks left to add
        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv_c) begin
                    a_q <= a_bnd[k];
                    b_q <= b_bnd[k];
                end
            end

            assign a_bnd[k+1] = a_q;
            assign b_bnd[k+1] = b_q;
        end
    end

    // Signed overflow: carry into MSB differs from carry out of MSB
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv_c) begin
            ovf_q <= co_c[STAGES-1] ^ cmsb_c[STAGES-1];
        end
    end

    assign bus.out_valid = ctrl_bnd[STAGES].valid;
    assign bus.sum       = s_bnd[STAGES];
    assign bus.cout      = ctrl_bnd[STAGES].carry;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_add_pipe_nbit.sv
// Self-checking bench for add_pipe_nbit: 16/4 pipe against an arithmetic model, plus a 4/4 instance.
module tb_add_pipe_nbit;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    add_pipe_nbit_if #(.WIDTH(16)) bus16 ();
    add_pipe_nbit_if #(.WIDTH(4))  bus4 ();

    add_pipe_nbit #(.WIDTH(16), .CHUNK(4)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
    add_pipe_nbit #(.WIDTH(4),  .CHUNK(4)) u_dut4  (.clk(clk), .rst(rst), .bus(bus4));

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, unsigned for sum/carry and signed for overflow
    function automatic res_t ref_model(input logic [15:0] a, input logic [15:0] b,
                                       input logic cin, input logic sub);
        int   ur;
        int   sr;
        res_t r;
        if (sub) begin
            ur     = int'(a) - int'(b) - int'(cin);
            sr     = int'($signed(a)) - int'($signed(b)) - int'(cin);
            r.cout = (ur >= 0);
        end else begin
            ur     = int'(a) + int'(b) + int'(cin);
            sr     = int'($signed(a)) + int'($signed(b)) + int'(cin);
            r.cout = (ur > 65535);
        end
        r.sum = ur[15:0];
        r.ovf = (sr > 32767) || (sr < -32768);
        return r;
    endfunction

    // Drive one beat into an empty pipe and report edges-to-result (-1 if it never appears)
    task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic cin,
                            input logic sub, output int lat, output res_t res);
        @(negedge clk);
        bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.sub = sub;
        bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        lat = -1;
        res = '0;
        for (int i = 1; i <= 12; i++) begin
            if (bus16.out_valid === 1'b1) begin
                lat = i;
                res = {bus16.sum, bus16.cout, bus16.ovf};
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus16.out_valid !== 1'b0 || bus16.sum !== 16'h0 || bus16.cout !== 1'b0 || bus16.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset16: valid=%b sum=%h cout=%b ovf=%b, want all zero",
                     bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf);
        end
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.sum !== 4'h0 || bus4.cout !== 1'b0) begin
            errors++;
            $display("FAIL reset4: valid=%b sum=%h cout=%b, want all zero", bus4.out_valid, bus4.sum, bus4.cout);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus16.in_ready !== 1'b1 || bus4.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready16=%b in_ready4=%b, want 1 1", bus16.in_ready, bus4.in_ready);
        end
    endtask

    task automatic test_wraparound();
        int   lat;
        res_t got;
        send_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, got);
        checks++;
        if (lat != 4 || got !== {16'h0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wrap: lat=%0d sum=%h cout=%b ovf=%b, want lat=4 sum=0000 cout=1 ovf=0",
                     lat, got.sum, got.cout, got.ovf);
        end
    endtask

    task automatic test_overflow();
        int   lat;
        res_t got;
        send_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, got);
        checks++;
        if (lat != 4 || got !== {16'h8000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ovf_add: lat=%0d sum=%h cout=%b ovf=%b, want lat=4 sum=8000 cout=0 ovf=1",
                     lat, got.sum, got.cout, got.ovf);
        end
        send_one(16'h8000, 16'h0001, 1'b0, 1'b1, lat, got);
        checks++;
        if (lat != 4 || got !== {16'h7FFF, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ovf_sub: lat=%0d sum=%h cout=%b ovf=%b, want lat=4 sum=7fff cout=1 ovf=1",
                     lat, got.sum, got.cout, got.ovf);
        end
    endtask

    task automatic test_subtract();
        int   lat;
        res_t got;
        send_one(16'h0005, 16'h0007, 1'b0, 1'b1, lat, got);
        checks++;
        if (lat != 4 || got !== {16'hFFFE, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub: lat=%0d sum=%h cout=%b ovf=%b, want lat=4 sum=fffe cout=0 ovf=0",
                     lat, got.sum, got.cout, got.ovf);
        end
        send_one(16'h0005, 16'h0007, 1'b1, 1'b1, lat, got);
        checks++;
        if (lat != 4 || got !== {16'hFFFD, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub_borrow: lat=%0d sum=%h cout=%b ovf=%b, want lat=4 sum=fffd cout=0 ovf=0",
                     lat, got.sum, got.cout, got.ovf);
        end
    endtask

    task automatic test_back_to_back();
        res_t q[$];
        res_t got;
        res_t want;
        res_t prev_res;
        int   sent;
        int   recv;
        int   cyc;
        logic pend;
        logic prev_stall;
        sent = 0; recv = 0; cyc = 0; pend = 1'b0; prev_stall = 1'b0; prev_res = '0;
        while ((sent < 32 || q.size() != 0) && cyc < 2000) begin
            @(negedge clk);
            if (prev_stall) begin
                got = {bus16.sum, bus16.cout, bus16.ovf};
                checks++;
                if (bus16.out_valid !== 1'b1 || got !== prev_res) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b res=%h, want valid=1 res=%h", bus16.out_valid, got, prev_res);
                end
            end
            if (!pend && sent < 32) begin
                bus16.a   = 16'($urandom);
                bus16.b   = 16'($urandom);
                bus16.cin = 1'($urandom);
                bus16.sub = 1'($urandom);
                pend      = 1'b1;
            end
            bus16.in_valid  = pend;
            bus16.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (bus16.in_ready !== (~bus16.out_valid | bus16.out_ready)) begin
                errors++;
                $display("FAIL in_ready: got %b, want %b", bus16.in_ready, ~bus16.out_valid | bus16.out_ready);
            end
            if (bus16.out_valid === 1'b1 && bus16.out_ready === 1'b1) begin
                got = {bus16.sum, bus16.cout, bus16.ovf};
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra: unexpected result %h", got);
                end else begin
                    want = q.pop_front();
                    recv++;
                    if (got !== want) begin
                        errors++;
                        $display("FAIL stream_beat%0d: got %h, want %h", recv, got, want);
                    end
                end
            end
            if (pend && bus16.in_ready === 1'b1) begin
                q.push_back(ref_model(bus16.a, bus16.b, bus16.cin, bus16.sub));
                sent++;
                pend = 1'b0;
            end
            prev_stall = (bus16.out_valid === 1'b1) && (bus16.out_ready === 1'b0);
            prev_res   = {bus16.sum, bus16.cout, bus16.ovf};
            cyc++;
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        checks++;
        if (recv != 32 || q.size() != 0) begin
            errors++;
            $display("FAIL stream_count: received %0d pending %0d, want 32 and 0", recv, q.size());
        end
    endtask

    task automatic test_reset_midflight();
        int   lat;
        res_t got;
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus16.a = 16'h1111 * 16'(i + 1); bus16.b = 16'h0101;
            bus16.cin = 1'b0; bus16.sub = 1'b0; bus16.in_valid = 1'b1;
        end
        @(negedge clk);
        bus16.in_valid = 1'b0;
        rst = 1'b1;
        checks++;
        if (bus16.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midflight_early: out_valid=%b, want 0", bus16.out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus16.out_valid !== 1'b0 || bus16.sum !== 16'h0 || bus16.cout !== 1'b0 || bus16.ovf !== 1'b0) begin
            errors++;
            $display("FAIL midflight_flush: valid=%b sum=%h cout=%b ovf=%b, want all zero",
                     bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (bus16.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midflight_ghost: out_valid=%b sum=%h, want no result", bus16.out_valid, bus16.sum);
            end
        end
        send_one(16'h1234, 16'h4321, 1'b1, 1'b0, lat, got);
        checks++;
        if (lat != 4 || got !== {16'h5556, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL post_reset: lat=%0d sum=%h cout=%b ovf=%b, want lat=4 sum=5556 cout=0 ovf=0",
                     lat, got.sum, got.cout, got.ovf);
        end
    endtask

    task automatic test_width4();
        logic [4:0] want;
        logic [4:0] got;
        bus4.out_ready = 1'b1;
        bus4.sub       = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 512; n++) begin
            bus4.a        = 4'(n >> 5);
            bus4.b        = 4'(n >> 1);
            bus4.cin      = 1'(n);
            bus4.in_valid = 1'b1;
            want = 5'((n >> 5) + ((n >> 1) & 15) + (n & 1));
            @(negedge clk);
            got = {bus4.cout, bus4.sum};
            checks++;
            if (bus4.out_valid !== 1'b1 || got !== want) begin
                errors++;
                $display("FAIL w4 a=%0d b=%0d cin=%0d: valid=%b {cout,sum}=%0d, want valid=1 %0d",
                         n >> 5, (n >> 1) & 15, n & 1, bus4.out_valid, got, want);
            end
        end
        bus4.in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
        bus16.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.sub = 1'b0;
        bus4.out_ready = 1'b1;

        test_reset();
        test_wraparound();
        test_overflow();
        test_subtract();
        test_back_to_back();
        test_reset_midflight();
        test_width4();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
